// File: rtl/dm_lsu.sv
// dm_lsu: byte-addressed RV32I load/store unit over on-chip word RAM,
// with configurable response latency and misalignment/range/funct3 fault reporting.
module dm_lsu #(
    parameter int ADDR_W  = 16,
    parameter int DEPTH   = 1024,
    parameter int LATENCY = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req,
    input  logic              we,
    input  logic [2:0]        funct3,
    input  logic [ADDR_W-1:0] addr,
    input  logic [31:0]       wd,
    output logic              ready,
    output logic              done,
    output logic [31:0]       rd,
    output logic              err
);
    localparam int IW = DEPTH > 1 ? $clog2(DEPTH) : 1;

    typedef enum logic [1:0] {IDLE, WAIT, RESP} state_e;

    state_e            state_q, state_d;
    logic [1:0]        cnt_q, cnt_d;
    logic [31:0]       rd_q, rd_d;
    logic              err_q, err_d;
    logic [31:0]       mem_q [DEPTH] = '{default: '0};

    logic              acc, in_range, legal, misal, fault, sgn;
    logic [ADDR_W-3:0] word_a;
    logic [IW-1:0]     idx;
    logic [31:0]       word, load_v, wdata;
    logic [7:0]        b;
    logic [15:0]       h;
    logic [3:0]        be;

    assign ready    = state_q != WAIT;
    assign done     = state_q == RESP;
    assign rd       = rd_q;
    assign err      = err_q;
    assign acc      = req && ready && !rst;

    assign word_a   = addr[ADDR_W-1:2];
    assign idx      = IW'(word_a);
    assign in_range = 32'(word_a) < 32'(DEPTH);
    assign legal    = we ? funct3 <= 3'd2 : funct3 inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5};
    assign misal    = (funct3[1:0] == 2'd1 && addr[0]) || (funct3[1:0] == 2'd2 && addr[1:0] != 2'd0);
    assign fault    = !legal || misal || !in_range;

    // Loads are extended at acceptance so later stores cannot disturb the held result.
    assign word     = in_range ? mem_q[idx] : 32'd0;
    assign b        = word[{addr[1:0], 3'b000} +: 8];
    assign h        = addr[1] ? word[31:16] : word[15:0];
    assign sgn      = !funct3[2];
    assign load_v   = funct3[1:0] == 2'd0 ? {{24{sgn & b[7]}}, b} :
                      funct3[1:0] == 2'd1 ? {{16{sgn & h[15]}}, h} : word;

    assign be       = funct3[1:0] == 2'd0 ? 4'b0001 << addr[1:0] :
                      funct3[1:0] == 2'd1 ? (addr[1] ? 4'b1100 : 4'b0011) : 4'b1111;
    assign wdata    = funct3[1:0] == 2'd0 ? {4{wd[7:0]}} :
                      funct3[1:0] == 2'd1 ? {2{wd[15:0]}} : wd;

    always_ff @(posedge clk) begin
        if (acc && we && !fault) begin
            for (int i = 0; i < 4; i++) begin
                if (be[i]) mem_q[idx][8*i +: 8] <= wdata[8*i +: 8];
            end
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        rd_d    = rd_q;
        err_d   = err_q;
        if (state_q == WAIT) begin
            state_d = cnt_q == 2'd0 ? RESP : WAIT;
            cnt_d   = cnt_q == 2'd0 ? 2'd0 : cnt_q - 2'd1;
        end else if (acc) begin
            state_d = LATENCY == 0 ? RESP : WAIT;
            cnt_d   = LATENCY == 0 ? 2'd0 : 2'(LATENCY - 1);
            err_d   = fault;
            rd_d    = fault || we ? 32'd0 : load_v;
        end else begin
            state_d = IDLE;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= 2'd0;
            rd_q    <= 32'd0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            rd_q    <= rd_d;
            err_q   <= err_d;
        end
    end
endmodule

// File: tb/tb_dm_lsu.sv
// tb_dm_lsu: three dm_lsu instances (LATENCY 0/1/3) share one stimulus stream and are
// checked every cycle against a transaction-level memory model, plus literal expectations.
module tb_dm_lsu;
    localparam int DEPTH = 1024;
    localparam int LATS [3] = '{0, 1, 3};

    logic        clk = 1'b0, rst = 1'b1, req = 1'b0, we = 1'b0;
    logic [2:0]  funct3 = 3'd0;
    logic [15:0] addr = 16'd0;
    logic [31:0] wd = 32'd0;
    logic        ready_w [3], done_w [3], err_w [3];
    logic [31:0] rd_w [3];
    int          n_chk = 0, n_fail = 0;

    always #5 clk = ~clk;

    for (genvar g = 0; g < 3; g++) begin : g_dut
        dm_lsu #(.ADDR_W(16), .DEPTH(DEPTH), .LATENCY(LATS[g])) u_dut (
            .clk(clk), .rst(rst), .req(req), .we(we), .funct3(funct3), .addr(addr), .wd(wd),
            .ready(ready_w[g]), .done(done_w[g]), .rd(rd_w[g]), .err(err_w[g])
        );
    end

    bit [31:0] mm [3][DEPTH];
    int        edge_n = 0;
    int        rdy_at [3] = '{0, 0, 0};
    int        p_due [3] = '{0, 0, 0};
    bit        m_rdy [3] = '{1, 1, 1};
    bit        p_v [3] = '{0, 0, 0};
    bit        x_done [3] = '{0, 0, 0};
    bit        p_err [3] = '{0, 0, 0};
    bit [31:0] p_rd [3] = '{0, 0, 0};

    task automatic model_access(int k);
        int a, sz;
        bit [31:0] v;
        bit legal;
        a = int'(addr);
        sz = funct3[1:0] == 2'd0 ? 1 : funct3[1:0] == 2'd1 ? 2 : 4;
        legal = we ? funct3 <= 3'd2 : funct3 inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5};
        p_err[k] = !legal || (a % sz) != 0 || (a / 4) >= DEPTH;
        p_rd[k] = 32'd0;
        if (p_err[k]) return;
        if (we) begin
            for (int i = 0; i < sz; i++) mm[k][a/4][8*((a%4)+i) +: 8] = wd[8*i +: 8];
        end else begin
            v = mm[k][a/4] >> (8 * (a % 4));
            if (sz == 1) v = funct3[2] ? (v & 32'hFF) : {{24{v[7]}}, v[7:0]};
            if (sz == 2) v = funct3[2] ? (v & 32'hFFFF) : {{16{v[15]}}, v[15:0]};
            p_rd[k] = v;
        end
    endtask

    initial forever begin
        @(posedge clk);
        edge_n++;
        for (int k = 0; k < 3; k++) begin
            if (rst) begin
                p_v[k] = 1'b0;
                rdy_at[k] = edge_n;
            end else if (req && m_rdy[k]) begin
                model_access(k);
                p_v[k] = 1'b1;
                p_due[k] = edge_n + LATS[k];
                rdy_at[k] = edge_n + LATS[k];
            end
            m_rdy[k] = edge_n >= rdy_at[k];
            x_done[k] = !rst && p_v[k] && p_due[k] == edge_n;
        end
    end

    task automatic chk(string nm, int k, logic [31:0] act, logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s[lat%0d] @%0t: got %h expected %h", nm, LATS[k], $time, act, exp);
        end
    endtask

    task automatic tick();
        @(negedge clk);
        for (int k = 0; k < 3; k++) begin
            if (rst) begin
                chk("rst_ready", k, ready_w[k], 1);
                chk("rst_done", k, done_w[k], 0);
                chk("rst_rd", k, rd_w[k], 0);
                chk("rst_err", k, err_w[k], 0);
            end else begin
                chk("ready", k, ready_w[k], m_rdy[k]);
                chk("done", k, done_w[k], x_done[k]);
                if (x_done[k]) begin
                    chk("rd", k, rd_w[k], p_rd[k]);
                    chk("err", k, err_w[k], p_err[k]);
                end
            end
        end
    endtask

    task automatic issue(bit w, bit [2:0] f, bit [15:0] a, bit [31:0] d, bit [31:0] xrd, bit xerr);
        int nd [3], cyc [3];
        logic [31:0] grd [3];
        logic ger [3];
        for (int k = 0; k < 3; k++) begin
            nd[k] = 0; cyc[k] = 0; grd[k] = 32'd0; ger[k] = 1'b0;
        end
        req = 1'b1; we = w; funct3 = f; addr = a; wd = d;
        for (int n = 1; n <= 4; n++) begin
            tick();
            req = 1'b0;
            for (int k = 0; k < 3; k++) begin
                if (done_w[k] === 1'b1) begin
                    nd[k]++; cyc[k] = n; grd[k] = rd_w[k]; ger[k] = err_w[k];
                end
            end
        end
        for (int k = 0; k < 3; k++) begin
            chk("lit_done_count", k, nd[k], 1);
            chk("lit_done_cycle", k, cyc[k], LATS[k] + 1);
            chk("lit_rd", k, grd[k], xrd);
            chk("lit_err", k, ger[k], xerr);
        end
    endtask

    initial begin
        int nd2, a, r;
        repeat (2) tick();
        rst = 1'b0;
        tick();
        for (int i = 0; i < 32; i++) issue(1'b0, 3'd2, 16'(i * 4), 32'd0, 32'd0, 1'b0);
        issue(1'b1, 3'd2, 16'h0028, 32'h12, 32'd0, 1'b0);
        issue(1'b0, 3'd2, 16'h0028, 32'd0, 32'h12, 1'b0);
        issue(1'b1, 3'd2, 16'h0014, 32'hDEADBEEF, 32'd0, 1'b0);
        issue(1'b1, 3'd0, 16'h0015, 32'h7F, 32'd0, 1'b0);
        issue(1'b1, 3'd1, 16'h0016, 32'hF00F, 32'd0, 1'b0);
        issue(1'b0, 3'd2, 16'h0014, 32'd0, 32'hF00F7FEF, 1'b0);
        issue(1'b0, 3'd0, 16'h0014, 32'd0, 32'hFFFFFFEF, 1'b0);
        issue(1'b0, 3'd4, 16'h0014, 32'd0, 32'h000000EF, 1'b0);
        issue(1'b0, 3'd1, 16'h0016, 32'd0, 32'hFFFFF00F, 1'b0);
        issue(1'b0, 3'd5, 16'h0016, 32'd0, 32'h0000F00F, 1'b0);
        issue(1'b0, 3'd2, 16'h0002, 32'd0, 32'd0, 1'b1);
        issue(1'b1, 3'd1, 16'h0015, 32'h1234, 32'd0, 1'b1);
        issue(1'b0, 3'd3, 16'h0014, 32'd0, 32'd0, 1'b1);
        issue(1'b1, 3'd2, 16'h1000, 32'hFFFFFFFF, 32'd0, 1'b1);
        issue(1'b1, 3'd4, 16'h0014, 32'd0, 32'd0, 1'b1);
        issue(1'b0, 3'd2, 16'h0014, 32'd0, 32'hF00F7FEF, 1'b0);
        // Back-to-back on the zero-latency instance; the slower ones drop the second request.
        req = 1'b1; we = 1'b1; funct3 = 3'd2; addr = 16'h0054; wd = 32'hABC;
        tick();
        chk("b2b_ready1", 0, ready_w[0], 1);
        chk("b2b_done1", 0, done_w[0], 1);
        we = 1'b0; wd = 32'd0;
        tick();
        chk("b2b_ready2", 0, ready_w[0], 1);
        chk("b2b_done2", 0, done_w[0], 1);
        chk("b2b_rd2", 0, rd_w[0], 32'hABC);
        chk("b2b_err2", 0, err_w[0], 0);
        req = 1'b0;
        tick();
        chk("b2b_done3", 0, done_w[0], 0);
        repeat (4) tick();
        // Reset while the slowest instance is still waiting.
        req = 1'b1; we = 1'b0; funct3 = 3'd2; addr = 16'h0028;
        tick();
        req = 1'b0;
        tick();
        #1 rst = 1'b1;
        tick();
        for (int k = 0; k < 3; k++) begin
            chk("lit_rst_ready", k, ready_w[k], 1);
            chk("lit_rst_done", k, done_w[k], 0);
            chk("lit_rst_rd", k, rd_w[k], 0);
            chk("lit_rst_err", k, err_w[k], 0);
        end
        #1 rst = 1'b0;
        nd2 = 0;
        repeat (5) begin
            tick();
            if (done_w[2] === 1'b1) nd2++;
        end
        chk("lit_rst_no_done", 2, nd2, 0);
        issue(1'b0, 3'd2, 16'h0028, 32'd0, 32'h12, 1'b0);
        repeat (3000) begin
            req = $urandom_range(0, 9) < 7;
            we = 1'($urandom_range(0, 1));
            if ($urandom_range(0, 9) == 0) funct3 = 3'($urandom);
            else if (we) funct3 = 3'($urandom_range(0, 2));
            else begin
                r = $urandom_range(0, 4);
                funct3 = r < 3 ? 3'(r) : 3'(r + 1);
            end
            a = $urandom_range(0, 127);
            if ($urandom_range(0, 1) == 1) a = a & ~3;
            if ($urandom_range(0, 19) == 0) a = $urandom_range(0, 65535);
            addr = 16'(a);
            wd = $urandom;
            if ($urandom_range(0, 299) == 0) begin
                tick();
                #1 rst = 1'b1;
                tick();
                #1 rst = 1'b0;
            end else begin
                tick();
            end
        end
        req = 1'b0;
        repeat (5) tick();
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
